spike_logger: RTL and testbench
===============================

Name: spike_logger

Overview:
- Downstream of the spike-detector top: consumes the registered `spike` level and turns each new spike into one timestamped event.
- Applies a refractory dead-time and buffers event timestamps in a FWFT FIFO.
- Drains through a valid/ready port to the readout/host interface.
- Keeps saturating accepted-event and dropped-event counters.

Parameters:
- TS_W, 16, timestamp width in samples; wraps modulo 2^TS_W.
- DEPTH, 16, FIFO depth in entries; power of two, 2..256.
- REFR, 32, refractory period in sample ticks after an accepted event; 0 disables it.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- sample_en, input, 1, one-cycle strobe per ADC sample, the same strobe that advances the front-end chain.
- spike, input, 1, detector output (level).
- clear, input, 1, synchronous soft clear; same effect as rst.
- ts_valid, output, 1, FIFO head valid.
- ts_data, output, TS_W, timestamp at FIFO head.
- ts_ready, input, 1, consumer accepts head when ts_valid && ts_ready.
- evt_count, output, CNT_W, accepted events, saturating.
- drop_count, output, 8, events lost to a full FIFO, saturating at 255.
- overflow, output, 1, sticky; set on first drop.

Behaviour:
- Reset/clear (rst or clear high at a clk edge):
  - ts_cnt=0, spike_prev=0, refr_cnt=0.
  - FIFO emptied, so ts_valid=0; ts_data is don't-care while ts_valid=0, and the bench must not check it.
  - evt_count=0, drop_count=0, overflow=0.
  - rst/clear override every other input in that cycle, including an in-flight push or pop.
- Timestamp: on each sample_en, ts_cnt <= ts_cnt+1, wrapping from 2^TS_W-1 to 0. No other cycle changes it.
- Edge detect: evaluated only in cycles with sample_en=1.
  - raw_evt = spike && !spike_prev.
  - spike_prev <= spike, updated only on sample_en.
- Refractory:
  - Accept when raw_evt && refr_cnt==0.
  - On accept, refr_cnt <= REFR.
  - Otherwise, on sample_en with refr_cnt>0, refr_cnt decrements.
  - A raw_evt while refr_cnt>0 is ignored and not counted as a drop.
  - Next accept is possible at the (REFR+1)-th sample after the accepting sample.
- Push on accept: data = ts_cnt value before this cycle's increment.
  - If FIFO not full, or a pop happens in the same cycle: write, and evt_count saturating-increments.
  - If full with no same-cycle pop: event dropped; drop_count saturating-increments; overflow <= 1; evt_count unchanged.
- Pop: on ts_valid && ts_ready.
  - Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged, order preserved.
  - Push into an empty FIFO: the word is not visible in the same cycle.
- Latency: accepted event at edge N gives ts_valid=1 after edge N, showing that timestamp if the FIFO was empty.
- FWFT output:
  - ts_valid = !empty.
  - ts_data = head entry; stable while ts_valid && !ts_ready.
- Counters hold at max; no wrap.
- spike is sampled only with sample_en; spike pulses that fall between strobes are ignored by design.

Decomposition:
- Package spike_log_pkg: TS_W/DEPTH/REFR defaults, ts_t typedef (logic [TS_W-1:0]), DROP_W=8 constant.
- Sub-module sync_fifo: parameterised width and depth, FWFT.
  - Ports: clk, rst, push, din, pop, dout, empty, full.
  - Must support simultaneous push/pop when full.
- spike_logger top holds the timestamp, edge detect, refractory logic and counters.

Test Plan:
- Reset: rst=1 for 3 cycles with spike=1 and sample_en toggling -> ts_valid=0, evt_count=0, drop_count=0, overflow=0; ts_cnt=0 after release.
- Single spike: sample_en every cycle; spike rises at sample 10 and holds 5 samples; ts_ready=1 -> exactly one beat with ts_data=10, evt_count=1.
- Refractory, REFR=32: rising edges at samples 10, 30 and 43 -> samples 10 and 43 accepted, 30 ignored, drop_count=0.
  - Recheck with REFR=0: edges at 10 and 12 -> both logged.
- Overflow, DEPTH=16, REFR=0, ts_ready=0: 20 separated edges -> 16 stored, drop_count=4, overflow=1, evt_count=16.
  - Then ts_ready=1 -> the first 16 timestamps drain in order.
- Full with simultaneous pop: FIFO full, accept and pop in the same cycle -> no drop, occupancy stays 16, new timestamp appears last.
- Wrap and clear, TS_W=4: event at sample 17 -> ts_data=1.
  - clear mid-burst with 3 entries queued -> ts_valid=0 next cycle; counters and overflow return to 0.

Source files
------------

// File: rtl/spike_logger_pkg.sv
// Shared defaults and types for the spike event logger.
package spike_log_pkg;

  localparam int unsigned DEF_TS_W  = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_REFR  = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DROP_W    = 8;

  typedef logic [DEF_TS_W-1:0] ts_t;

endpackage

// File: rtl/spike_logger_if.sv
// Valid/ready timestamp stream from the logger to the readout side.
interface spike_logger_if
  import spike_log_pkg::*;
#(
  parameter int unsigned TS_W = DEF_TS_W
);
  logic            ts_valid;
  logic [TS_W-1:0] ts_data;
  logic            ts_ready;

  modport master (output ts_valid, output ts_data, input ts_ready);
  modport slave  (input ts_valid, input ts_data, output ts_ready);
endinterface

// File: rtl/spike_logger_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a full FIFO still accepts a push
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (Depth is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spike_logger.sv
// Turns rising edges of the sampled spike level into timestamped events,
// applies a refractory dead-time, queues timestamps and counts accepts/drops.
module spike_logger
  import spike_log_pkg::*;
#(
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned REFR  = DEF_REFR,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              spike,
  input  logic              clear,
  spike_logger_if.master    ts,
  output logic [CNT_W-1:0]  evt_count,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow
);
  localparam int unsigned RW = (REFR > 0) ? $clog2(REFR + 1) : 1;

  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic              spike_prev_q, spike_prev_d;
  logic [RW-1:0]     refr_cnt_q, refr_cnt_d;
  logic [CNT_W-1:0]  evt_count_q, evt_count_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;

  logic              accept, push, pop, fifo_rst, fifo_empty, fifo_full;
  logic [TS_W-1:0]   fifo_dout;

  assign fifo_rst    = rst || clear;
  assign ts.ts_valid = !fifo_empty;
  assign ts.ts_data  = fifo_dout;
  assign pop         = !fifo_empty && ts.ts_ready;
  assign accept      = sample_en && spike && !spike_prev_q && (refr_cnt_q == '0);
  // A same-cycle pop frees the slot even when the FIFO reads full.
  assign push        = accept && (!fifo_full || pop);

  assign evt_count  = evt_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

  sync_fifo #(
    .Width(TS_W),
    .Depth(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (fifo_rst),
    .push (push),
    .din  (ts_cnt_q),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Timestamp, edge-detect, refractory and counter next-state.
  always_comb begin
    ts_cnt_d     = ts_cnt_q;
    spike_prev_d = spike_prev_q;
    refr_cnt_d   = refr_cnt_q;
    evt_count_d  = evt_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (sample_en) begin
      ts_cnt_d     = ts_cnt_q + TS_W'(1);
      spike_prev_d = spike;
      if (accept) begin
        refr_cnt_d = RW'(REFR);
      end else if (refr_cnt_q != '0) begin
        refr_cnt_d = refr_cnt_q - RW'(1);
      end
    end
    if (push && (evt_count_q != '1)) evt_count_d = evt_count_q + CNT_W'(1);
    if (accept && !push) begin
      if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
      overflow_d = 1'b1;
    end
  end

  // State register; rst and clear both return everything to idle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ts_cnt_q     <= '0;
      spike_prev_q <= 1'b0;
      refr_cnt_q   <= '0;
      evt_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ts_cnt_q     <= ts_cnt_d;
      spike_prev_q <= spike_prev_d;
      refr_cnt_q   <= refr_cnt_d;
      evt_count_q  <= evt_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_spike_logger.sv
// Bench: three logger configurations share one stimulus stream and are each
// compared every cycle against a queue-based model of the event rules.
module tb_spike_logger;
  import spike_log_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, clear = 1'b0, sample_en = 1'b0, spike = 1'b0, rdy = 1'b0;

  spike_logger_if #(.TS_W(16)) if_a ();
  spike_logger_if #(.TS_W(16)) if_b ();
  spike_logger_if #(.TS_W(4))  if_c ();
  assign if_a.ts_ready = rdy;
  assign if_b.ts_ready = rdy;
  assign if_c.ts_ready = rdy;

  logic [15:0] evt_a, evt_b;
  logic [3:0]  evt_c;
  logic [7:0]  drop_a, drop_b, drop_c;
  logic        ovf_a, ovf_b, ovf_c;

  spike_logger #(.TS_W(16), .DEPTH(16), .REFR(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .sample_en(sample_en), .spike(spike), .clear(clear),
    .ts(if_a), .evt_count(evt_a), .drop_count(drop_a), .overflow(ovf_a));
  spike_logger #(.TS_W(16), .DEPTH(16), .REFR(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .spike(spike), .clear(clear),
    .ts(if_b), .evt_count(evt_b), .drop_count(drop_b), .overflow(ovf_b));
  spike_logger #(.TS_W(4), .DEPTH(4), .REFR(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .sample_en(sample_en), .spike(spike), .clear(clear),
    .ts(if_c), .evt_count(evt_c), .drop_count(drop_c), .overflow(ovf_c));

  logic [31:0] obs_valid [3], obs_data [3], obs_evt [3], obs_drop [3], obs_ovf [3];
  assign obs_valid[0] = 32'(if_a.ts_valid);
  assign obs_valid[1] = 32'(if_b.ts_valid);
  assign obs_valid[2] = 32'(if_c.ts_valid);
  assign obs_data[0]  = 32'(if_a.ts_data);
  assign obs_data[1]  = 32'(if_b.ts_data);
  assign obs_data[2]  = 32'(if_c.ts_data);
  assign obs_evt[0]   = 32'(evt_a);
  assign obs_evt[1]   = 32'(evt_b);
  assign obs_evt[2]   = 32'(evt_c);
  assign obs_drop[0]  = 32'(drop_a);
  assign obs_drop[1]  = 32'(drop_b);
  assign obs_drop[2]  = 32'(drop_c);
  assign obs_ovf[0]   = 32'(ovf_a);
  assign obs_ovf[1]   = 32'(ovf_b);
  assign obs_ovf[2]   = 32'(ovf_c);

  function automatic int unsigned p_tsmod(int k);  return (k == 2) ? 16 : 65536;   endfunction
  function automatic int unsigned p_depth(int k);  return (k == 2) ? 4 : 16;       endfunction
  function automatic int unsigned p_refr(int k);   return (k == 0) ? 32 : (k == 1) ? 0 : 3; endfunction
  function automatic int unsigned p_cntmax(int k); return (k == 2) ? 15 : 65535;   endfunction

  // Model: sample index since reset, last accepted sample index, timestamp queue.
  int unsigned m_samp [3], m_last [3], m_evt [3], m_drop [3];
  bit          m_prev [3], m_has [3], m_ovf [3];
  int unsigned mq [3][$];

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %0h want %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit pop, acc;
      int unsigned ts;
      if (rst || clear) begin
        m_samp[k] = 0; m_last[k] = 0; m_evt[k] = 0; m_drop[k] = 0;
        m_prev[k] = 0; m_has[k] = 0; m_ovf[k] = 0;
        mq[k].delete();
      end else begin
        pop = (mq[k].size() != 0) && rdy;
        acc = 0;
        ts  = m_samp[k] % p_tsmod(k);
        if (sample_en) begin
          if (spike && !m_prev[k] &&
              (!m_has[k] || (m_samp[k] - m_last[k] >= p_refr(k) + 1))) begin
            acc = 1;
            m_has[k]  = 1;
            m_last[k] = m_samp[k];
          end
          m_prev[k] = spike;
          m_samp[k]++;
        end
        if (pop) void'(mq[k].pop_front());
        if (acc) begin
          if (mq[k].size() < p_depth(k)) begin
            mq[k].push_back(ts);
            if (m_evt[k] < p_cntmax(k)) m_evt[k]++;
          end else begin
            if (m_drop[k] < 255) m_drop[k]++;
            m_ovf[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk("valid", k, obs_valid[k], 32'(mq[k].size() != 0));
      if (mq[k].size() != 0) chk("data", k, obs_data[k], mq[k][0]);
      chk("evt_count", k, obs_evt[k], m_evt[k]);
      chk("drop_count", k, obs_drop[k], m_drop[k]);
      chk("overflow", k, obs_ovf[k], 32'(m_ovf[k]));
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit se, input bit sp, input bit rd);
    rst = r; clear = c; sample_en = se; spike = sp; rdy = rd;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int beats;
    logic [31:0] beat_data;
    logic [31:0] got [$];
    bit sp, rd;

    // Reset held with spike high and sample_en toggling.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, i[0], 1'b1, 1'b1);
    chk("rst_valid", 0, obs_valid[0], 0);
    chk("rst_evt", 0, obs_evt[0], 0);
    // First sample after release: timestamp must start at zero.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_ts0_valid", 0, obs_valid[0], 1);
    chk("rst_ts0_data", 0, obs_data[0], 0);

    // Single spike held for 5 samples starting at sample 10.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    beats = 0; beat_data = '0;
    for (int s = 0; s < 25; s++) begin
      if (obs_valid[0] == 1) begin beats++; beat_data = obs_data[0]; end
      cyc(1'b0, 1'b0, 1'b1, (s >= 10) && (s < 15), 1'b1);
    end
    chk("single_beats", 0, 32'(beats), 1);
    chk("single_data", 0, beat_data, 10);
    chk("single_evt", 0, obs_evt[0], 1);

    // Refractory: edges at 10, 30, 43.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 60; s++)
      cyc(1'b0, 1'b0, 1'b1, (s == 10) || (s == 30) || (s == 43), 1'b1);
    chk("refr32_evt", 0, obs_evt[0], 2);
    chk("refr32_drop", 0, obs_drop[0], 0);
    chk("refr0_evt", 1, obs_evt[1], 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 16; s++) cyc(1'b0, 1'b0, 1'b1, (s == 10) || (s == 12), 1'b1);
    chk("refr0_close_evt", 1, obs_evt[1], 2);

    // Overflow: 20 edges at even samples 0..38 with the consumer stalled.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 40; s++) cyc(1'b0, 1'b0, 1'b1, (s % 2) == 0, 1'b0);
    chk("ovf_evt", 1, obs_evt[1], 16);
    chk("ovf_drop", 1, obs_drop[1], 4);
    chk("ovf_flag", 1, obs_ovf[1], 1);
    // Full FIFO: accept at sample 40 with a same-cycle pop.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("fullpop_drop", 1, obs_drop[1], 4);
    chk("fullpop_evt", 1, obs_evt[1], 17);
    for (int i = 0; i < 20; i++) begin
      if (obs_valid[1] == 1) got.push_back(obs_data[1]);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("drain_len", 1, 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("drain_order", 1, got[i], (i < 15) ? 32'(2 * (i + 1)) : 32'd40);

    // Timestamp wrap on the 4-bit configuration: sample 17 -> 1.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 21; s++) cyc(1'b0, 1'b0, 1'b1, s == 17, 1'b0);
    chk("wrap_valid", 2, obs_valid[2], 1);
    chk("wrap_data", 2, obs_data[2], 1);

    // Counter saturation: stalled burst, then a flowing burst.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 1200; s++) cyc(1'b0, 1'b0, 1'b1, (s % 2) == 0, 1'b0);
    for (int s = 0; s < 200; s++)  cyc(1'b0, 1'b0, 1'b1, (s % 2) == 0, 1'b1);
    chk("drop_sat", 1, obs_drop[1], 255);
    chk("evt_sat", 2, obs_evt[2], 15);
    // Queue three entries, then clear with everything else active.
    for (int s = 0; s < 6; s++) cyc(1'b0, 1'b0, 1'b1, (s % 2) == 0, 1'b0);
    chk("pre_clear_valid", 1, obs_valid[1], 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_valid", 1, obs_valid[1], 0);
    chk("clear_evt", 1, obs_evt[1], 0);
    chk("clear_drop", 1, obs_drop[1], 0);
    chk("clear_ovf", 1, obs_ovf[1], 0);

    // Randomized traffic with occasional clear/reset.
    sp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) sp = ~sp;
      rd = ($urandom_range(0, 3) != 0) ^ (i >= 1500 && i < 2000);
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 499) == 0,
          1'($urandom_range(0, 1)), sp, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
